// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the femto bus initiator.
// Bus data/access-size widths, access-size codes, status codes, FSM states
// and the local alignment check used when a command is accepted.
package bus_initiator_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  // Access-size codes; 2'd3 is reserved and always rejected as misaligned.
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  typedef enum logic [1:0] {
    BUSI_OK       = 2'd0,
    BUSI_FAULT    = 2'd1,
    BUSI_TIMEOUT  = 2'd2,
    BUSI_MISALIGN = 2'd3
  } busi_status_e;

  typedef enum logic [1:0] {
    BUSI_IDLE  = 2'd0,
    BUSI_ISSUE = 2'd1,
    BUSI_WAIT  = 2'd2,
    BUSI_DONE  = 2'd3
  } busi_state_e;

  // Only the two low address bits matter for alignment.
  function automatic logic busi_misaligned(input logic [1:0]               addr_lo,
                                           input logic [BUS_ACC_WIDTH-1:0] acc);
    case (acc)
      BUS_ACC_1B: busi_misaligned = 1'b0;
      BUS_ACC_2B: busi_misaligned = addr_lo[0];
      BUS_ACC_4B: busi_misaligned = |addr_lo;
      default:    busi_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_initiator.sv
// Initiator end of the femto peripheral bus.
// Accepts one command at a time (cmd_valid/cmd_ready), issues a single bus
// transaction (one-cycle req), and reports rdata plus status on a one-cycle
// rsp_valid strobe. Misaligned commands are rejected locally without a bus
// cycle; a slave that never answers is cut off after TIMEOUT WAIT cycles.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_addr/cmd_w_rb/cmd_acc/cmd_wdata  command fields
//   rsp_valid/rsp_rdata/rsp_status result strobe, data, status
//   addr/w_rb/acc/wdata/req        bus request side (registered)
//   rdata/resp/fault               bus response side from the slave
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [AW-1:0]            cmd_addr,
  input  logic                     cmd_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] cmd_acc,
  input  logic [BUS_WIDTH-1:0]     cmd_wdata,
  output logic                     rsp_valid,
  output logic [BUS_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]               rsp_status,
  output logic [AW-1:0]            addr,
  output logic                     w_rb,
  output logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     wdata,
  output logic                     req,
  input  logic [BUS_WIDTH-1:0]     rdata,
  input  logic                     resp,
  input  logic                     fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  busi_state_e              state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     w_rb_q, w_rb_d;
  logic [BUS_ACC_WIDTH-1:0] acc_q, acc_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  busi_status_e             rsp_status_q, rsp_status_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BUSI_IDLE;
      addr_q       <= '0;
      w_rb_q       <= 1'b0;
      acc_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= BUSI_OK;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      w_rb_q       <= w_rb_d;
      acc_q        <= acc_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    w_rb_d       = w_rb_q;
    acc_d        = acc_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      BUSI_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          w_rb_d  = cmd_w_rb;
          acc_d   = cmd_acc;
          wdata_d = cmd_wdata;
          if (busi_misaligned(cmd_addr[1:0], cmd_acc)) begin
            state_d      = BUSI_DONE;
            rsp_status_d = BUSI_MISALIGN;
            rsp_rdata_d  = '0;
          end else begin
            state_d = BUSI_ISSUE;
          end
        end
      end
      BUSI_ISSUE: begin
        // fault is combinational from the slave and only meaningful here.
        if (fault) begin
          state_d      = BUSI_DONE;
          rsp_status_d = BUSI_FAULT;
          rsp_rdata_d  = '0;
        end else begin
          state_d = BUSI_WAIT;
          cnt_d   = '0;
        end
      end
      BUSI_WAIT: begin
        // resp takes priority over an expiring timeout in the same cycle.
        if (resp) begin
          state_d      = BUSI_DONE;
          rsp_status_d = BUSI_OK;
          rsp_rdata_d  = w_rb_q ? '0 : rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = BUSI_DONE;
          rsp_status_d = BUSI_TIMEOUT;
          rsp_rdata_d  = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSI_DONE: state_d = BUSI_IDLE;
      default:   state_d = BUSI_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == BUSI_IDLE);
  assign req        = (state_q == BUSI_ISSUE);
  assign rsp_valid  = (state_q == BUSI_DONE);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign addr       = addr_q;
  assign w_rb       = w_rb_q;
  assign acc        = acc_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed vector table, a reset
// abort sequence, and randomized commands against a behavioural model.
module tb_bus_initiator;
  import bus_initiator_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_w_rb;
  logic [1:0]  cmd_acc;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] wdata;
  logic        req;
  logic [31:0] rdata;
  logic        resp;
  logic        fault;

  bus_initiator #(.AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_w_rb(cmd_w_rb), .cmd_acc(cmd_acc), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
    .rdata(rdata), .resp(resp), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Command, slave behaviour (fault in req cycle, response delay k, read
  // data) and expected result (status, cycles from accept to rsp_valid, data).
  typedef struct {
    logic [31:0] addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic        flt;
    int          k;
    logic [31:0] sd;
    logic [1:0]  e_st;
    int          e_lat;
    logic [31:0] e_rd;
  } vec_t;

  // Reference model straight from the bus rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [1:0] lo = v.addr[1:0];
    bit mis = (v.acc == 2'd3) || (v.acc == BUS_ACC_2B && lo[0]) ||
              (v.acc == BUS_ACC_4B && lo != 2'd0);
    if (mis) begin
      r.e_st = BUSI_MISALIGN; r.e_lat = 1; r.e_rd = 0;
    end else if (v.flt) begin
      r.e_st = BUSI_FAULT; r.e_lat = 2; r.e_rd = 0;
    end else if (v.k <= TO) begin
      r.e_st = BUSI_OK; r.e_lat = 2 + v.k; r.e_rd = v.w_rb ? 32'd0 : v.sd;
    end else begin
      r.e_st = BUSI_TIMEOUT; r.e_lat = 2 + TO; r.e_rd = 0;
    end
    return r;
  endfunction

  // Entered #1 after a rising edge with the DUT idle. Cycle 0 is the accept
  // cycle; each later cycle is checked for req, rsp_valid, cmd_ready and
  // stable bus fields. With junk set, the source keeps offering a different
  // command while busy and the slave wiggles resp/fault/rdata where they
  // must be ignored.
  task automatic run_txn(input vec_t v, input bit junk, input string tag);
    chk({tag, " ready_at_accept"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_w_rb  = v.w_rb;
    cmd_acc   = v.acc;
    cmd_wdata = v.wdata;
    for (int cyc = 1; cyc <= v.e_lat + 1; cyc++) begin
      @(posedge clk); #1;
      if (junk && cyc <= v.e_lat) begin
        cmd_valid = 1'b1;
        cmd_addr  = $urandom;
        cmd_w_rb  = 1'($urandom);
        cmd_acc   = 2'($urandom);
        cmd_wdata = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc == 1 + v.k) resp = 1'b1;
      else                resp = (junk && cyc == 1) ? 1'($urandom) : 1'b0;
      if (cyc == 1) fault = v.flt;
      else          fault = junk ? 1'($urandom) : 1'b0;
      rdata = (cyc == 1 + v.k) ? v.sd : (junk ? $urandom : 32'd0);

      chk({tag, " req"}, 32'(req), 32'(cyc == 1 && v.e_st != BUSI_MISALIGN));
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(cyc == v.e_lat));
      chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'(cyc > v.e_lat));
      if (cyc <= v.e_lat) begin
        chk({tag, " addr_hold"}, addr, v.addr);
        chk({tag, " wdata_hold"}, wdata, v.wdata);
        chk({tag, " ctl_hold"}, {29'd0, w_rb, acc}, {29'd0, v.w_rb, v.acc});
      end
      if (cyc == v.e_lat) begin
        chk({tag, " status"}, 32'(rsp_status), 32'(v.e_st));
        chk({tag, " rdata"}, rsp_rdata, v.e_rd);
      end
    end
    cmd_valid = 1'b0;
    resp = 1'b0; fault = 1'b0; rdata = '0;
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_addr = 0; cmd_w_rb = 0; cmd_acc = 0;
    cmd_wdata = 0; rdata = 0; resp = 0; fault = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset req", 32'(req), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_status", 32'(rsp_status), 32'(BUSI_OK));
    chk("reset addr", addr, 32'd0);
    chk("reset wdata", wdata, 32'd0);
    chk("reset ctl", {30'd0, acc} | 32'(w_rb), 32'd0);

    //         addr         w  acc         wdata  flt k   sd            status         lat rdata
    tbl[0] = '{32'h0,       1, BUS_ACC_1B, 32'h0,  0, 1,  32'h0,        BUSI_OK,       3, 32'h0};
    tbl[1] = '{32'h10,      0, BUS_ACC_4B, 32'h0,  0, 3,  32'hDEADBEEF, BUSI_OK,       5, 32'hDEADBEEF};
    tbl[2] = '{32'h0,       1, BUS_ACC_1B, 32'hFF, 1, 1,  32'h0,        BUSI_FAULT,    2, 32'h0};
    tbl[3] = '{32'h102,     0, BUS_ACC_4B, 32'h0,  0, 1,  32'h0,        BUSI_MISALIGN, 1, 32'h0};
    tbl[4] = '{32'h101,     1, BUS_ACC_2B, 32'h5,  0, 1,  32'h0,        BUSI_MISALIGN, 1, 32'h0};
    tbl[5] = '{32'h0,       0, 2'd3,       32'h0,  0, 1,  32'h0,        BUSI_MISALIGN, 1, 32'h0};
    tbl[6] = '{32'h102,     0, BUS_ACC_2B, 32'h0,  0, 99, 32'h0,        BUSI_TIMEOUT,  6, 32'h0};
    tbl[7] = '{32'h7,       0, BUS_ACC_1B, 32'h0,  0, 4,  32'h5A,       BUSI_OK,       6, 32'h5A};
    tbl[8] = '{32'h20,      1, BUS_ACC_4B, 32'hAB, 0, 2,  32'h1234,     BUSI_OK,       4, 32'h0};
    for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset while waiting for resp; a late resp must not produce a result.
    cmd_valid = 1; cmd_addr = 32'h40; cmd_w_rb = 0; cmd_acc = BUS_ACC_4B; cmd_wdata = 0;
    @(posedge clk); #1 cmd_valid = 0;
    chk("rstabort req", 32'(req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    chk("rstabort in_wait", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0; resp = 1'b1; rdata = 32'h77;
    chk("rstabort ready", 32'(cmd_ready), 32'd1);
    chk("rstabort no_rsp0", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 resp = 1'b0; rdata = 0;
      chk("rstabort no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(model('{32'h44, 0, BUS_ACC_4B, 32'h0, 0, 2, 32'hCAFE0001, 0, 0, 0}), 1'b0, "after_rst");

    // Randomized commands with ignored-signal noise.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.addr  = $urandom;
      v.w_rb  = 1'($urandom);
      v.acc   = 2'($urandom);
      v.wdata = $urandom;
      v.flt   = ($urandom_range(0, 3) == 0);
      v.k     = $urandom_range(1, TO + 2);
      v.sd    = $urandom;
      v.e_st  = 0; v.e_lat = 0; v.e_rd = 0;
      run_txn(model(v), 1'b1, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
